// File: rtl/sha256_sigma_unit.sv
// sha256_sigma_unit: SHA-256 Σ0, Σ1 and σ0 of one word in parallel, optionally registered.
module sha256_sigma_unit #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] x,
  output logic        out_valid,
  output logic [31:0] big_sigma0,
  output logic [31:0] big_sigma1,
  output logic [31:0] small_sigma0
);
  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction
  logic [31:0] bs0_d, bs1_d, ss0_d;
  assign bs0_d = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  assign bs1_d = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  assign ss0_d = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  generate
    if (OUT_REG) begin : g_reg
      logic [31:0] bs0_q, bs1_q, ss0_q;
      logic        vld_q;
      // Data only loads on valid words so it holds across idle cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          bs0_q <= '0;
          bs1_q <= '0;
          ss0_q <= '0;
        end else begin
          vld_q <= in_valid;
          if (in_valid) begin
            bs0_q <= bs0_d;
            bs1_q <= bs1_d;
            ss0_q <= ss0_d;
          end
        end
      end
      assign out_valid    = vld_q;
      assign big_sigma0   = bs0_q;
      assign big_sigma1   = bs1_q;
      assign small_sigma0 = ss0_q;
    end else begin : g_comb
      assign out_valid    = in_valid;
      assign big_sigma0   = bs0_d;
      assign big_sigma1   = bs1_d;
      assign small_sigma0 = ss0_d;
    end
  endgenerate
endmodule

// File: tb/tb_sha256_sigma_unit.sv
// tb_sha256_sigma_unit: scoreboard bench for registered and combinational sigma units.
module tb_sha256_sigma_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, ov;
  logic [31:0] x, bs0, bs1, ss0;
  logic        vc, ovc;
  logic [31:0] xc, bs0c, bs1c, ss0c;
  int          tests = 0, fails = 0;
  logic [95:0] q[$];

  always #5 clk = ~clk;

  sha256_sigma_unit #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .out_valid(ov), .big_sigma0(bs0), .big_sigma1(bs1), .small_sigma0(ss0)
  );
  sha256_sigma_unit #(.OUT_REG(1'b0)) dutc (
    .clk(clk), .rst(rst), .in_valid(vc), .x(xc),
    .out_valid(ovc), .big_sigma0(bs0c), .big_sigma1(bs1c), .small_sigma0(ss0c)
  );

  function automatic logic [31:0] rr(input logic [31:0] v, input int n);
    logic [63:0] w;
    w = {v, v} >> n;
    return w[31:0];
  endfunction

  function automatic logic [95:0] model(input logic [31:0] v);
    return {rr(v, 2) ^ rr(v, 13) ^ rr(v, 22),
            rr(v, 6) ^ rr(v, 11) ^ rr(v, 25),
            rr(v, 7) ^ rr(v, 18) ^ {3'b000, v[31:3]}};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov) begin
      if (q.size() == 0) check("unexpected_out_valid", {bs0, bs1, ss0}, 96'hx);
      else check("stream", {bs0, bs1, ss0}, q.pop_front());
    end
  end

  task automatic issue(input logic [31:0] v, input logic [95:0] exp);
    @(posedge clk);
    #1 in_valid = 1'b1;
    x = v;
    q.push_back(exp);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; x = 32'hFFFFFFFF; vc = 1'b0; xc = '0;
    #3;
    check("async_reset_valid", ov, 0);
    check("async_reset_data", {bs0, bs1, ss0}, 96'h0);
    repeat (2) @(negedge clk);
    check("reset_hold_valid", ov, 0);
    check("reset_hold_data", {bs0, bs1, ss0}, 96'h0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    settle();
    check("post_reset_valid", ov, 0);
    check("post_reset_data", {bs0, bs1, ss0}, 96'h0);
    issue(32'h00003FFF, {32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780});
    issue(32'h00000001, {32'h40080400, 32'h04200080, 32'h02004000});
    issue(32'h00000000, 96'h0);
    issue(32'hFFFFFFFF, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF});
    idle();
    settle();
    check("idle_valid_low", ov, 0);
    check("idle_hold_ones", {bs0, bs1, ss0}, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF});
    issue(32'h00000001, {32'h40080400, 32'h04200080, 32'h02004000});
    issue(32'h00003FFF, {32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780});
    issue(32'h00000000, 96'h0);
    idle();
    settle();
    check("stream_idle_valid", ov, 0);
    check("stream_hold_zero", {bs0, bs1, ss0}, 96'h0);
    issue(32'h00000001, {32'h40080400, 32'h04200080, 32'h02004000});
    idle();
    settle();
    settle();
    check("hold_single_bit", {bs0, bs1, ss0}, {32'h40080400, 32'h04200080, 32'h02004000});
    @(posedge clk);
    #1 in_valid = 1'b1; x = 32'h00003FFF; rst = 1'b1;
    #2;
    check("midstream_reset_data", {bs0, bs1, ss0}, 96'h0);
    check("midstream_reset_valid", ov, 0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    settle();
    check("reset_wins_valid", ov, 0);
    check("reset_wins_data", {bs0, bs1, ss0}, 96'h0);
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] v;
      v = $urandom;
      issue(v, model(v));
    end
    idle();
    settle();
    check("queue_drained", q.size(), 0);
    check("final_valid_low", ov, 0);
    for (int i = 0; i < 2000; i++) begin
      xc = $urandom;
      vc = 1'($urandom_range(0, 1));
      #1;
      check("comb_valid", ovc, vc);
      check("comb_data", {bs0c, bs1c, ss0c}, model(xc));
    end
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      xc = a ^ b;
      #1;
      check("comb_linear", {bs0c, bs1c, ss0c}, model(a) ^ model(b));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
